uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receive-side handshake and status bundle for uart_rx
// master is the receiver, slave is the byte consumer.
interface uart_rx_if #(
  parameter int FIFO_DEPTH = 16
);
  logic [7:0]                    data_o;
  logic                          valid_o;
  logic                          ready_i;
  logic [$clog2(FIFO_DEPTH):0]   level_o;
  logic                          frame_err_o;
  logic                          overrun_o;

  modport master (
    output data_o, valid_o, level_o, frame_err_o, overrun_o,
    input  ready_i
  );

  modport slave (
    input  data_o, valid_o, level_o, frame_err_o, overrun_o,
    output ready_i
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and receive storage
// UART_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx #(
  parameter int FREQ_HZ    = 16000000,
  parameter int BAUDS      = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic      clk,
  input  logic      reset_ni,
  input  logic      rx_i,
  uart_rx_if.master bus
);
  localparam int DIV = (FREQ_HZ + 8 * BAUDS) / (16 * BAUDS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          sync1, sync2, line_prev;
  logic [1:0]    warm;
  logic [DW-1:0] div_cnt;
  logic [1:0]    state;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    samp;
  logic [7:0]    shreg;
  logic          tick, start_edge, decide, bit_end, majority;
  logic          push_req, push, pop, full, valid;
  logic [LW-1:0] level;
  logic [7:0]    head;

  // line_prev only follows the line once the synchronizer holds real samples,
  // so a line that is low at reset release is not mistaken for a start edge.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      warm      <= 2'b00;
      line_prev <= 1'b0;
    end else begin
      sync1     <= rx_i;
      sync2     <= sync1;
      warm      <= {warm[0], 1'b1};
      line_prev <= warm[1] & sync2;
    end
  end

  assign start_edge = (state == IDLE) && line_prev && !sync2;
  assign tick       = (div_cnt == DW'(DIV - 1));
  assign decide     = tick && (tick_cnt == 4'd9);
  assign bit_end    = tick && (tick_cnt == 4'd15);
  assign majority   = (samp[0] & samp[1]) | (samp[0] & sync2) | (samp[1] & sync2);

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni)
      div_cnt <= '0;
    else if (start_edge || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + DW'(1);
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= IDLE;
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      samp     <= 2'b00;
      shreg    <= 8'h00;
    end else if (state == IDLE) begin
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      if (start_edge)
        state <= START;
    end else begin
      if (tick) begin
        tick_cnt <= tick_cnt + 4'd1;
        if (tick_cnt == 4'd7) samp[0] <= sync2;
        if (tick_cnt == 4'd8) samp[1] <= sync2;
      end
      if (state == START) begin
        if (decide && majority)
          state <= IDLE;
        else if (bit_end)
          state <= DATA;
      end else if (state == DATA) begin
        if (decide)
          shreg <= {majority, shreg[7:1]};
        if (bit_end) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state <= STOP;
        end
      end else if (decide) begin
        state <= IDLE;
      end
    end
  end

  assign push_req = (state == STOP) && decide && majority;
  assign pop      = valid && bus.ready_i;
  assign push     = push_req && (!full || pop);

`ifdef UART_RX_FIFO_EN
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        level <= level + LW'(1);
      else if (pop && !push)
        level <= level - LW'(1);
    end
  end

  assign full  = (level == LW'(FIFO_DEPTH));
  assign valid = (level != '0);
  assign head  = valid ? mem[rd_ptr] : 8'h00;
`else
  logic [7:0] hold;
  logic       held;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      hold <= 8'h00;
      held <= 1'b0;
    end else if (push) begin
      hold <= shreg;
      held <= 1'b1;
    end else if (pop) begin
      held <= 1'b0;
    end
  end

  assign full  = held;
  assign valid = held;
  assign level = {{AW{1'b0}}, held};
  assign head  = held ? hold : 8'h00;
`endif

  assign bus.data_o      = head;
  assign bus.valid_o     = valid;
  assign bus.level_o     = level;
  assign bus.frame_err_o = (state == STOP) && decide && !majority;
  assign bus.overrun_o   = push_req && full && !pop;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 16 MHz / 115200 baud
// Works with and without UART_RX_FIFO_EN.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int BIT = 144;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1;
`endif
  // Stop-bit majority decision edge, counted from the posedge that launches the start bit.
  localparam int STOP_DECIDE = 1389;

  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  logic rx = 1'b1;

  uart_rx_if #(.FIFO_DEPTH(16)) bus ();

  uart_rx #(
    .FREQ_HZ   (16000000),
    .BAUDS     (115200),
    .FIFO_DEPTH(16)
  ) dut (
    .clk     (clk),
    .reset_ni(reset_ni),
    .rx_i    (rx),
    .bus     (bus)
  );

  always #31.25 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      wait_cycles(BIT);
    end
  endtask

  always @(negedge clk) begin
    if (reset_ni) begin
      if (bus.valid_o && bus.ready_i) begin
        n_pops++;
        if (exp_q.size() == 0)
          check("pop_with_nothing_expected", 32'(exp_q.size()), 32'd1);
        else
          check("pop_data", {24'h0, bus.data_o}, {24'h0, exp_q.pop_front()});
      end
      if (bus.frame_err_o) n_ferr++;
      if (bus.overrun_o)   n_ovr++;
    end
  end

  initial begin
    #6250000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bus.ready_i = 1'b0;
    wait_cycles(5);
    check("reset_valid",   {31'h0, bus.valid_o},     32'd0);
    check("reset_level",   {27'h0, bus.level_o},     32'd0);
    check("reset_data",    {24'h0, bus.data_o},      32'd0);
    check("reset_ferr",    {31'h0, bus.frame_err_o}, 32'd0);
    check("reset_overrun", {31'h0, bus.overrun_o},   32'd0);
    reset_ni = 1'b1;
    wait_cycles(10);

    // clean byte with consumer ready
    bus.ready_i = 1'b1;
    p0 = n_pops;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    wait_cycles(10);
    check("a5_pops",    32'(n_pops - p0), 32'd1);
    check("a5_ferr",    32'(n_ferr),      32'd0);
    check("a5_overrun", 32'(n_ovr),       32'd0);
    check("a5_level",   {27'h0, bus.level_o}, 32'd0);

    // 3-tick low glitch on idle line
    p0 = n_pops;
    rx = 1'b0;
    wait_cycles(27);
    rx = 1'b1;
    wait_cycles(2 * BIT);
    check("glitch_pops", 32'(n_pops - p0), 32'd0);
    check("glitch_ferr", 32'(n_ferr),      32'd0);

    // framing error followed by a held break
    p0 = n_pops;
    send_byte(8'h3C, 1'b0);
    wait_cycles(3 * BIT);
    check("ferr_count", 32'(n_ferr), 32'd1);
    check("ferr_level", {27'h0, bus.level_o}, 32'd0);
    check("ferr_pops",  32'(n_pops - p0), 32'd0);
    rx = 1'b1;
    wait_cycles(BIT);

    // fill storage, then one byte too many
    bus.ready_i = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH)
        exp_q.push_back(8'(i));
      else
        check("overrun_before_last", 32'(n_ovr), 32'd0);
      send_byte(8'(i), 1'b1);
    end
    wait_cycles(5);
    check("full_level",         {27'h0, bus.level_o}, 32'(DEPTH));
    check("overrun_after_last", 32'(n_ovr), 32'd1);

    // pop coinciding with the push of 0x55 while full
    exp_q.push_back(8'h55);
    fork
      send_byte(8'h55, 1'b1);
      begin
        wait_cycles(STOP_DECIDE - 1);
        bus.ready_i = 1'b1;
        wait_cycles(1);
        bus.ready_i = 1'b0;
        @(negedge clk);
        check("pushpop_level", {27'h0, bus.level_o}, 32'(DEPTH));
      end
    join
    wait_cycles(5);
    check("pushpop_overrun", 32'(n_ovr), 32'd1);

    // drain in order
    bus.ready_i = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++)
      wait_cycles(1);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    wait_cycles(3);
    check("drain_level", {27'h0, bus.level_o}, 32'd0);
    check("drain_valid", {31'h0, bus.valid_o}, 32'd0);

    // reset in the middle of a frame with bytes queued
    bus.ready_i = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_cycles(5);
    check("queued_level", {27'h0, bus.level_o}, (DEPTH >= 2) ? 32'd2 : 32'd1);
    fork
      send_byte(8'h81, 1'b1);
      begin
        wait_cycles(5 * BIT + 40);
        reset_ni = 1'b0;
        wait_cycles(3);
        check("midreset_level", {27'h0, bus.level_o}, 32'd0);
        check("midreset_valid", {31'h0, bus.valid_o}, 32'd0);
        reset_ni = 1'b1;
      end
    join
    wait_cycles(BIT);
    check("postreset_level", {27'h0, bus.level_o}, 32'd0);
    bus.ready_i = 1'b1;
    p0 = n_pops;
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    wait_cycles(10);
    check("postreset_pops", 32'(n_pops - p0), 32'd1);
    check("postreset_ferr", 32'(n_ferr), 32'd1);
    check("final_queue",    32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
